msg_queue: RTL and testbench

Downstream buffering stage for `msg_parser`. It captures each message that the parser emits, including its length and payload, into a small register-array FIFO. It then presents messages one at a time to the consumer over a valid/ready handshake. The parser has no back-pressure on its message outputs, so this block also filters out parser-flagged and out-of-range messages, drops on overflow, and keeps saturating statistics counters.

---
 rtl/msg_queue.sv | 109 ++++++++++
 tb/tb_msg_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_queue.sv
// Message buffering FIFO behind msg_parser: filters bad/overlong messages, masks payload
// bytes beyond the message length, and presents entries over a valid/ready handshake.
module msg_queue #(
  parameter int MSG_DATA_WIDTH = 256,
  parameter int MIN_MSG_BYTES  = 8,
  parameter int MAX_MSG_BYTES  = 32,
  parameter int DEPTH          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        msg_valid,
  input  logic [15:0]                 msg_length,
  input  logic [MSG_DATA_WIDTH-1:0]   msg_data,
  input  logic                        msg_error,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0]                 out_length,
  output logic [MSG_DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  output logic [15:0]                 err_count,
  output logic [15:0]                 len_err_count,
  output logic [15:0]                 drop_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int NB = MSG_DATA_WIDTH / 8;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

  // Handshake: an entry transfers on a rising edge where out_valid && out_ready;
  // out_valid/out_length/out_data hold steady while out_valid && !out_ready.

  logic [MSG_DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [15:0]               r_len [DEPTH];
  logic [PW-1:0]             r_wr_ptr;
  logic [PW-1:0]             r_rd_ptr;
  logic [LW-1:0]             r_level;
  logic                      r_overflow;
  logic [15:0]               r_err_count;
  logic [15:0]               r_len_err_count;
  logic [15:0]               r_drop_count;

  logic                      w_empty;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_len_bad;
  logic                      w_candidate;
  logic                      w_push;
  logic                      w_drop;
  logic [MSG_DATA_WIDTH-1:0] w_masked;

  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == FULL_LVL);
  assign w_pop       = !w_empty && out_ready;
  assign w_len_bad   = (msg_length < 16'(MIN_MSG_BYTES)) || (msg_length > 16'(MAX_MSG_BYTES));
  assign w_candidate = msg_valid && !msg_error && !w_len_bad;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_push      = w_candidate && (!w_full || w_pop);
  assign w_drop      = w_candidate && w_full && !w_pop;

  always_comb begin
    w_masked = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(msg_length)) w_masked[b*8 +: 8] = msg_data[b*8 +: 8];
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_masked;
      r_len[r_wr_ptr] <= msg_length;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_overflow      <= 1'b0;
      r_err_count     <= '0;
      r_len_err_count <= '0;
      r_drop_count    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push && w_pop) r_level <= r_level - LW'(1);
      if (w_drop) r_overflow <= 1'b1;
      if (msg_error && (r_err_count != CNT_MAX))
        r_err_count <= r_err_count + 16'd1;
      if (msg_valid && !msg_error && w_len_bad && (r_len_err_count != CNT_MAX))
        r_len_err_count <= r_len_err_count + 16'd1;
      if (w_drop && (r_drop_count != CNT_MAX))
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign out_valid     = !w_empty;
  assign out_length    = w_empty ? 16'd0 : r_len[r_rd_ptr];
  assign out_data      = w_empty ? '0 : r_mem[r_rd_ptr];
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign err_count     = r_err_count;
  assign len_err_count = r_len_err_count;
  assign drop_count    = r_drop_count;
endmodule

// File: tb/tb_msg_queue.sv
// Bench for msg_queue: directed table, hand-written corner sequences and random traffic,
// all checked against a queue-based reference model.
module tb_msg_queue;
  localparam int W = 256;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_valid;
  logic [15:0]   msg_length;
  logic [W-1:0]  msg_data;
  logic          msg_error;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_length;
  logic [W-1:0]  out_data;
  logic [2:0]    level;
  logic          overflow;
  logic [15:0]   err_count;
  logic [15:0]   len_err_count;
  logic [15:0]   drop_count;

  msg_queue #(.MSG_DATA_WIDTH(W), .MIN_MSG_BYTES(8), .MAX_MSG_BYTES(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_length(msg_length),
    .msg_data(msg_data), .msg_error(msg_error), .out_valid(out_valid),
    .out_ready(out_ready), .out_length(out_length), .out_data(out_data),
    .level(level), .overflow(overflow), .err_count(err_count),
    .len_err_count(len_err_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted messages plus scalar counters.
  logic [W-1:0] exp_q[$];
  logic [15:0]  exp_len_q[$];
  int           m_err, m_len_err, m_drop;
  bit           m_ovf;
  int           n_cmp, n_bad;
  bit           chk_en;
  int           dut_pops;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mask_bytes(input logic [W-1:0] d, input int len);
    logic [W-1:0] r;
    r = '0;
    for (int b = 0; b < W/8; b++) if (b < len) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 65535) ? 65535 : c + 1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    exp_len_q.delete();
    m_err = 0; m_len_err = 0; m_drop = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit v, input int len, input logic [W-1:0] d,
                            input bit err, input bit rdy);
    bit pop, full;
    pop  = (exp_q.size() > 0) && rdy;
    full = (exp_q.size() == DEPTH);
    if (err) m_err = sat_inc(m_err);
    if (v && !err) begin
      if (len < 8 || len > 32) m_len_err = sat_inc(m_len_err);
      else if (full && !pop) begin
        m_drop = sat_inc(m_drop);
        m_ovf  = 1;
      end else begin
        exp_q.push_back(mask_bytes(d, len));
        exp_len_q.push_back(16'(len));
      end
    end
    if (pop) begin
      void'(exp_q.pop_front());
      void'(exp_len_q.pop_front());
    end
  endtask

  task automatic check_model();
    bit ne;
    ne = exp_q.size() > 0;
    chk("out_valid", W'(out_valid), W'(ne));
    chk("out_length", W'(out_length), ne ? W'(exp_len_q[0]) : '0);
    chk("out_data", out_data, ne ? exp_q[0] : '0);
    chk("level", W'(level), W'(exp_q.size()));
    chk("overflow", W'(overflow), W'(m_ovf));
    chk("err_count", W'(err_count), W'(m_err));
    chk("len_err_count", W'(len_err_count), W'(m_len_err));
    chk("drop_count", W'(drop_count), W'(m_drop));
  endtask

  // One clock: apply inputs, let the edge happen, update the model, compare 1 time unit later.
  task automatic drive(input bit v, input int len, input logic [W-1:0] d,
                       input bit err, input bit rdy);
    msg_valid  = v;
    msg_length = 16'(len);
    msg_data   = d;
    msg_error  = err;
    out_ready  = rdy;
    #1;
    if (out_valid && out_ready) dut_pops++;
    @(posedge clk);
    model_step(v, len, d, err, rdy);
    #1;
    if (chk_en) check_model();
  endtask

  task automatic idle_inputs();
    msg_valid = 0; msg_length = '0; msg_data = '0; msg_error = 0; out_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    model_clear();
    #1;
    check_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [W-1:0] d;
    for (int k = 0; k < W/32; k++) d[k*32 +: 32] = $urandom();
    return d;
  endfunction

  typedef struct {
    bit          v;
    bit          err;
    int          len;
    bit          rdy;
    bit          e_ov;
    logic [15:0] e_olen;
    logic [2:0]  e_lvl;
    logic [15:0] e_err;
    logic [15:0] e_lerr;
    logic [15:0] e_drop;
    bit          e_ovf;
  } vec_t;

  vec_t tbl[15];

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] exp_d;
    n_cmp = 0; n_bad = 0; chk_en = 1; dut_pops = 0;

    // Filtering, fill/overflow, in-order drain, max-length boundary.
    tbl[0]  = '{1, 0,  7, 1, 0,  0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 0, 33, 1, 0,  0, 0, 0, 2, 0, 0};
    tbl[2]  = '{1, 1, 10, 1, 0,  0, 0, 1, 2, 0, 0};
    tbl[3]  = '{0, 1,  0, 1, 0,  0, 0, 2, 2, 0, 0};
    tbl[4]  = '{1, 0,  8, 0, 1,  8, 1, 2, 2, 0, 0};
    tbl[5]  = '{1, 0, 14, 0, 1,  8, 2, 2, 2, 0, 0};
    tbl[6]  = '{1, 0,  8, 0, 1,  8, 3, 2, 2, 0, 0};
    tbl[7]  = '{1, 0, 12, 0, 1,  8, 4, 2, 2, 0, 0};
    tbl[8]  = '{1, 0, 17, 0, 1,  8, 4, 2, 2, 1, 1};
    tbl[9]  = '{0, 0,  0, 1, 1, 14, 3, 2, 2, 1, 1};
    tbl[10] = '{0, 0,  0, 1, 1,  8, 2, 2, 2, 1, 1};
    tbl[11] = '{0, 0,  0, 1, 1, 12, 1, 2, 2, 1, 1};
    tbl[12] = '{0, 0,  0, 1, 0,  0, 0, 2, 2, 1, 1};
    tbl[13] = '{1, 0, 32, 1, 1, 32, 1, 2, 2, 1, 1};
    tbl[14] = '{0, 0,  0, 1, 0,  0, 0, 2, 2, 1, 1};

    do_reset();

    // Single message, 1-cycle fall-through latency, upper bytes zeroed.
    d = rnd_data();
    d[63:0] = 64'h630d658d_abcddcef;
    exp_d = '0;
    exp_d[63:0] = 64'h630d658d_abcddcef;
    drive(1, 8, d, 0, 1);
    chk("single_valid", W'(out_valid), W'(1));
    chk("single_len", W'(out_length), W'(8));
    chk("single_data", out_data, exp_d);
    drive(0, 0, '0, 0, 1);
    chk("single_gone", W'(out_valid), W'(0));

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].len, rnd_data(), tbl[i].err, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_len", i), W'(out_length), W'(tbl[i].e_olen));
      chk($sformatf("tbl%0d_level", i), W'(level), W'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_err", i), W'(err_count), W'(tbl[i].e_err));
      chk($sformatf("tbl%0d_lerr", i), W'(len_err_count), W'(tbl[i].e_lerr));
      chk($sformatf("tbl%0d_drop", i), W'(drop_count), W'(tbl[i].e_drop));
      chk($sformatf("tbl%0d_ovf", i), W'(overflow), W'(tbl[i].e_ovf));
    end

    // Full FIFO with simultaneous push and pop: accepted, no drop.
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 9 + i, rnd_data(), 0, 0);
    drive(1, 20, rnd_data(), 0, 1);
    chk("fullpp_level", W'(level), W'(4));
    chk("fullpp_drop", W'(drop_count), W'(0));
    chk("fullpp_ovf", W'(overflow), W'(0));
    chk("fullpp_head", W'(out_length), W'(10));
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 0, 1);
    chk("fullpp_last", W'(out_length), W'(20));
    drive(0, 0, '0, 0, 1);
    chk("fullpp_empty", W'(level), W'(0));

    // Back-pressure with alternating ready, repeated to exercise pointer wrap.
    do_reset();
    dut_pops = 0;
    for (int rep = 0; rep < 10; rep++) begin
      drive(1, 8 + rep, rnd_data(), 0, 0);
      drive(1, 9 + rep, rnd_data(), 0, 0);
      for (int k = 0; k < 6; k++) drive(0, 0, '0, 0, bit'(k % 2));
    end
    chk("bp_pops", W'(dut_pops), W'(20));
    chk("bp_level", W'(level), W'(0));

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 40), rnd_data(),
            $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset with entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 8 + i, rnd_data(), 0, 0);
    chk("pre_rst_level", W'(level), W'(3));
    #2 rst = 1'b1;
    model_clear();
    #1;
    chk("rst_valid", W'(out_valid), W'(0));
    chk("rst_level", W'(level), W'(0));
    check_model();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Saturation of len_err_count.
    chk_en = 0;
    for (int i = 0; i < 70000; i++) drive(1, 3, '0, 0, 1);
    chk_en = 1;
    drive(1, 40, '0, 0, 1);
    chk("sat_len_err", W'(len_err_count), W'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
